// File: rtl/fd_reg_if.sv
// Fetch/decode boundary bus: F-side inputs from the PC unit/IM/hazard/CP0, D-side register outputs.
interface fd_reg_if;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic        F_bd;
    logic        stall;
    logic        Req;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic [4:0]  D_excCode;
    logic        D_bd;
    logic        D_valid;
    logic [31:0] fetch_cnt;

    modport master (
        output F_pc, F_instr, F_bd, stall, Req,
        input  D_pc, D_instr, D_excCode, D_bd, D_valid, fetch_cnt
    );

    modport slave (
        input  F_pc, F_instr, F_bd, stall, Req,
        output D_pc, D_instr, D_excCode, D_bd, D_valid, fetch_cnt
    );
endinterface

// File: rtl/fd_reg.sv
// F/D pipeline register with fetch-address (AdEL) detection, stall hold, CP0 flush
// and a debug count of instructions accepted into D.
module fd_reg (
    input  logic     clk,
    input  logic     reset,
    fd_reg_if.slave  bus
);
    localparam logic [31:0] PC_LO    = 32'h0000_3000;
    localparam logic [31:0] PC_HI    = 32'h0000_6FFC;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    logic fault;

    always_comb begin
        fault = (bus.F_pc[1:0] != 2'b00) || (bus.F_pc < PC_LO) || (bus.F_pc > PC_HI);
    end

    // Faulting fetches keep their PC so CP0 can take EPC/BadVAddr from D_pc.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.D_pc      <= PC_LO;
            bus.D_instr   <= 32'd0;
            bus.D_excCode <= 5'd0;
            bus.D_bd      <= 1'b0;
            bus.D_valid   <= 1'b0;
            bus.fetch_cnt <= 32'd0;
        end else if (bus.Req) begin
            bus.D_pc      <= EXC_VEC;
            bus.D_instr   <= 32'd0;
            bus.D_excCode <= 5'd0;
            bus.D_bd      <= 1'b0;
            bus.D_valid   <= 1'b0;
        end else if (!bus.stall) begin
            bus.D_pc      <= bus.F_pc;
            bus.D_instr   <= fault ? 32'd0 : bus.F_instr;
            bus.D_excCode <= fault ? EXC_ADEL : 5'd0;
            bus.D_bd      <= bus.F_bd;
            bus.D_valid   <= 1'b1;
            bus.fetch_cnt <= bus.fetch_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_fd_reg.sv
// Directed test-plan steps followed by randomized traffic, checked against a behavioural model.
module tb_fd_reg;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fd_reg_if ifc ();
    fd_reg dut (.clk(clk), .reset(reset), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural expectation of the D-side outputs
    longint m_pc, m_instr, m_exc, m_bd, m_valid, m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".D_pc"},      ifc.D_pc,             32'(m_pc));
        chk({tag, ".D_instr"},   ifc.D_instr,          32'(m_instr));
        chk({tag, ".D_excCode"}, {27'd0, ifc.D_excCode}, 32'(m_exc));
        chk({tag, ".D_bd"},      {31'd0, ifc.D_bd},    32'(m_bd));
        chk({tag, ".D_valid"},   {31'd0, ifc.D_valid}, 32'(m_valid));
        chk({tag, ".fetch_cnt"}, ifc.fetch_cnt,        32'(m_cnt));
    endtask

    // One clock edge: drive inputs, advance the model by the priority rules, compare 1ns after.
    task automatic step(input string tag, input bit rst_n, input bit req, input bit stl,
                        input logic [31:0] pc, input logic [31:0] instr, input bit bd);
        longint upc;
        bit     bad;
        reset = rst_n; ifc.Req = req; ifc.stall = stl;
        ifc.F_pc = pc; ifc.F_instr = instr; ifc.F_bd = bd;
        @(posedge clk);
        upc = longint'(pc);
        bad = (upc % 4 != 0) || (upc < 'h3000) || (upc > 'h6FFC);
        if (!rst_n) begin
            m_pc = 'h3000; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0; m_cnt = 0;
        end else if (req) begin
            m_pc = 'h4180; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
        end else if (!stl) begin
            m_pc = upc; m_bd = bd; m_valid = 1;
            m_instr = bad ? 0 : longint'(instr);
            m_exc = bad ? 4 : 0;
            m_cnt = (m_cnt + 1) % (64'd1 << 32);
        end
        #1;
        chk_all(tag);
    endtask

    initial begin
        logic [31:0] pc, cnt_hold;
        int          sel;
        m_pc = 0; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0; m_cnt = 0;

        step("rst0", 0, 0, 0, 32'h0, 32'h0, 0);
        step("rst1", 0, 1, 1, 32'h0, 32'h0, 1);
        chk("rst.D_pc_const", ifc.D_pc, 32'h0000_3000);
        chk("rst.cnt_const", ifc.fetch_cnt, 32'd0);

        step("load0", 1, 0, 0, 32'h3000, 32'h3C01_0001, 0);
        chk("load0.instr_const", ifc.D_instr, 32'h3C01_0001);
        chk("load0.cnt_const", ifc.fetch_cnt, 32'd1);

        step("load1", 1, 0, 0, 32'h3004, 32'h2421_0002, 0);
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 1, 32'h3008, 32'h1111_2222, 0);
        chk("stall.pc_const", ifc.D_pc, 32'h3004);
        step("unstall", 1, 0, 0, 32'h3008, 32'h1111_2222, 0);
        chk("unstall.pc_const", ifc.D_pc, 32'h3008);

        step("adel_mis", 1, 0, 0, 32'h3002, 32'hDEAD_BEEF, 0);
        chk("adel_mis.exc_const", {27'd0, ifc.D_excCode}, 32'd4);
        step("adel_lo", 1, 0, 0, 32'h2FFC, 32'hDEAD_BEEF, 0);
        step("adel_hi", 1, 0, 0, 32'h7000, 32'hDEAD_BEEF, 0);
        step("top_ok", 1, 0, 0, 32'h6FFC, 32'h0000_000C, 0);
        chk("top_ok.exc_const", {27'd0, ifc.D_excCode}, 32'd0);

        cnt_hold = ifc.fetch_cnt;
        step("flush", 1, 1, 1, 32'h3010, 32'h1234_5678, 1);
        chk("flush.pc_const", ifc.D_pc, 32'h0000_4180);
        chk("flush.cnt_hold", ifc.fetch_cnt, cnt_hold);
        step("after_flush", 1, 0, 0, 32'h4180, 32'h0000_0000, 0);

        step("bd", 1, 0, 0, 32'h3020, 32'h1000_FFFF, 1);
        step("stall_pre_rst", 1, 0, 1, 32'h3024, 32'h0, 0);
        step("rst_mid_stall", 0, 0, 1, 32'h3024, 32'h0, 0);
        step("rel_stalled", 1, 0, 1, 32'h3024, 32'h0, 0);
        chk("rel_stalled.valid_const", {31'd0, ifc.D_valid}, 32'd0);
        step("rel_load", 1, 0, 0, 32'h3024, 32'hABCD_0123, 0);

        force ifc.fetch_cnt = 32'hFFFF_FFFF;
        #1 release ifc.fetch_cnt;
        m_cnt = 'hFFFF_FFFF;
        step("wrap", 1, 0, 0, 32'h3028, 32'h0000_0001, 0);
        chk("wrap.cnt_const", ifc.fetch_cnt, 32'd0);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: pc = 32'h3000 + 32'($urandom_range(0, 'hFFF)) * 4;
                1: pc = 32'h3000 + 32'($urandom_range(0, 'h3FFF)) | 32'($urandom_range(1, 3));
                2: pc = ($urandom_range(0, 1) != 0) ? 32'h2FFC - 32'($urandom_range(0, 3)) * 4
                                                   : 32'h6FFC + 32'($urandom_range(0, 3)) * 4;
                default: pc = $urandom;
            endcase
            step("rand", $urandom_range(0, 99) >= 3, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0, pc, $urandom, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fd_reg.md
# fd_reg

Fetch/decode boundary register of the P8 five-stage MIPS pipeline. Sits directly downstream of the PC unit and instruction memory. It captures the fetched PC, instruction and delay-slot flag each cycle and detects fetch-address exceptions (AdEL), replacing the faulting instruction with a nop. It honours the hazard unit's stall and the CP0 interrupt/exception flush, and keeps a fetched-instruction counter for debug.

## Interface
- PC_LO, 32'h0000_3000, lowest legal fetch address
- PC_HI, 32'h0000_6FFC, highest legal fetch address (inclusive)
- EXC_VEC, 32'h0000_4180, PC loaded into D on flush
- EXC_ADEL, 5'd4, ExcCode for fetch address error
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; 0 at a rising edge resets all state
- F_pc  in  32  fetch-stage PC from PC unit
- F_instr  in  32  instruction word from IM for F_pc
- F_bd  in  1  1 = instruction at F_pc is a branch delay slot
- stall  in  1  hazard-unit stall; hold D contents
- Req  in  1  CP0 exception/interrupt request; flush D
- D_pc  out  32  registered PC
- D_instr  out  32  registered instruction (0 when faulting or flushed)
- D_excCode  out  5  registered exception code (0 = none)
- D_bd  out  1  registered delay-slot flag
- D_valid  out  1  1 = D holds a real fetched instruction, not a bubble
- fetch_cnt  out  32  count of instructions accepted into D with D_valid=1

## Operation
- Address check, combinational on F_pc: fault = (F_pc[1:0] != 0) or (F_pc < PC_LO) or (F_pc > PC_HI). Comparisons are unsigned, 32-bit.
- Per-edge priority: reset low > Req > stall > normal load.
- Reset: D_pc=PC_LO, D_instr=0, D_excCode=0, D_bd=0, D_valid=0, fetch_cnt=0.
- Req=1 (flush):
  - D_pc=EXC_VEC, D_instr=0, D_excCode=0, D_bd=0, D_valid=0.
  - fetch_cnt unchanged.
  - Req overrides stall.
- stall=1, Req=0: every D_* output and fetch_cnt hold their values.
- Normal load (Req=0, stall=0):
  - D_pc=F_pc, D_bd=F_bd, D_valid=1.
  - If fault: D_instr=0 and D_excCode=EXC_ADEL.
  - Otherwise: D_instr=F_instr and D_excCode=0.
  - fetch_cnt += 1, including faulting fetches.
- fetch_cnt wraps from 32'hFFFF_FFFF to 0 with no flag.
- D_pc keeps the faulting address on AdEL so CP0 can load EPC/BadVAddr from it downstream.
- A flushed slot (D_valid=0) carries D_pc=EXC_VEC. Downstream macroscopic-PC logic relies on this.
- No combinational path from any input to any output. All outputs are register outputs.

## Timing
- Latency: 1 cycle. Values at F at edge N appear on D_* after edge N.
- Stall is level-sensitive. D holds for exactly as many edges as stall is high, then loads the current F values on the first edge where stall=0.
- Req is single-edge effective. A Req pulse one cycle long produces exactly one bubble.
- Reset mid-operation: the next edge with reset=0 clears everything regardless of Req or stall. The first load occurs on the first edge with reset=1 and stall=0.
- Reset deassertion with stall=1: D stays at reset values, D_valid=0, until stall drops.

## Test plan
- Reset then normal fetch:
  - reset=0 for 2 cycles -> D_pc=0x3000, D_instr=0, D_valid=0, fetch_cnt=0.
  - Release with F_pc=0x3000, F_instr=0x3C010001 -> next cycle D_pc=0x3000, D_instr=0x3C010001, D_excCode=0, D_valid=1, fetch_cnt=1.
- Stall hold: load F_pc=0x3004/F_instr=0x24210002, then stall=1 for 3 cycles while F changes to 0x3008 -> D stays 0x3004/0x24210002, fetch_cnt constant. Drop stall -> D_pc=0x3008.
- AdEL:
  - F_pc=0x3002 -> D_instr=0, D_excCode=4, D_pc=0x3002, D_valid=1.
  - F_pc=0x2FFC and F_pc=0x7000 -> D_excCode=4.
  - F_pc=0x6FFC -> D_excCode=0.
- Flush priority: Req=1 and stall=1 together, F_pc=0x3010, F_bd=1 -> D_pc=0x4180, D_instr=0, D_bd=0, D_valid=0, D_excCode=0, fetch_cnt unchanged. Next cycle with Req=0, F_pc=0x4180 -> D_valid=1.
- Delay slot / reset mid-stall:
  - F_bd=1 with F_pc=0x3020 -> D_bd=1.
  - With stall=1, assert reset=0 for one edge -> all outputs return to reset values.
- Counter wrap: drive fetch_cnt to 0xFFFFFFFF by forcing or a long run, then perform 1 normal load -> fetch_cnt=0.
